// File: rtl/dense_weight_fetcher_if.sv
// ROM read port and output stream of the dense weight fetcher.
// master: fetcher side; slave: ROM and MAC-datapath side.
interface dense_weight_fetcher_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  rom_ena;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output rom_ena, rom_addr, m_valid, m_data, m_last,
    input  rom_q, m_ready
  );

  modport slave (
    input  rom_ena, rom_addr, m_valid, m_data, m_last,
    output rom_q, m_ready
  );
endinterface

// File: rtl/dense_weight_fetcher.sv
// Streams len consecutive weight-ROM words from base_addr through a 2-entry buffer.
// Optional FETCH_CHECKSUM_EN adds a 16-bit running sum of accepted beats.
module dense_weight_fetcher #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
`ifdef FETCH_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  dense_weight_fetcher_if.master bus
);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W  = 2;
  localparam int unsigned CRED_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        last_addr_q, last_addr_d;
  logic [ADDR_WIDTH-1:0]        addr_now;
  logic [CNT_W-1:0]             len_q, len_d;
  logic [CNT_W-1:0]             issued_q, issued_d;
  logic                         inflight_q, inflight_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [1:0][DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]                   last_q, last_d;
  logic                         busy_d, done_d;
  logic                         accept, pop, issue, push_last;
  logic [CRED_W-1:0]            credit;
`ifdef FETCH_CHECKSUM_EN
  logic [15:0]                  checksum_d;
`endif

  assign bus.m_valid  = (occ_q != '0);
  assign bus.m_data   = data_q[0];
  assign bus.m_last   = last_q[0];
  assign bus.rom_ena  = issue;
  assign bus.rom_addr = issue ? addr_now : last_addr_q;

  // Next-state, read issue and buffer bookkeeping
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    last_addr_d = last_addr_q;
    occ_d       = occ_q;
    data_d      = data_q;
    last_d      = last_q;
    busy_d      = busy;
    done_d      = 1'b0;
    inflight_d  = 1'b0;
`ifdef FETCH_CHECKSUM_EN
    checksum_d  = checksum;
`endif

    accept    = start && !busy && (state_q == S_IDLE);
    pop       = (occ_q != '0) && bus.m_ready;
    // A new read lands one cycle after the word now on rom_q, so count it as taken
    credit    = CRED_W'(occ_q) + CRED_W'(inflight_q) - CRED_W'(pop);
    issue     = (state_q == S_RUN) && (issued_q < len_q) && (credit < CRED_W'(2));
    addr_now  = base_q + issued_q[ADDR_WIDTH-1:0];
    push_last = (issued_q == len_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          busy_d   = 1'b1;
          state_d  = (len == '0) ? S_FLUSH : S_RUN;
`ifdef FETCH_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (issue) begin
          issued_d    = issued_q + CNT_W'(1);
          last_addr_d = addr_now;
          inflight_d  = 1'b1;
        end
        if (pop && last_q[0]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) busy_d = 1'b0;

    // Head entry is index 0; the word on rom_q is pushed the cycle after its read
    case ({inflight_q, pop})
      2'b10: begin
        data_d[occ_q[0]] = bus.rom_q;
        last_d[occ_q[0]] = push_last;
        occ_d            = occ_q + OCC_W'(1);
      end
      2'b01: begin
        data_d[0] = data_q[1];
        last_d[0] = last_q[1];
        occ_d     = occ_q - OCC_W'(1);
      end
      2'b11: begin
        if (occ_q[1]) begin
          data_d[0] = data_q[1];
          last_d[0] = last_q[1];
          data_d[1] = bus.rom_q;
          last_d[1] = push_last;
        end else begin
          data_d[0] = bus.rom_q;
          last_d[0] = push_last;
        end
      end
      default: ;
    endcase

`ifdef FETCH_CHECKSUM_EN
    if (pop) checksum_d = checksum + 16'(data_q[0]);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= '0;
      data_q      <= '0;
      last_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef FETCH_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      data_q      <= data_d;
      last_q      <= last_d;
      busy        <= busy_d;
      done        <= done_d;
`ifdef FETCH_CHECKSUM_EN
      checksum    <= checksum_d;
`endif
    end
  end
endmodule

// File: tb/tb_dense_weight_fetcher.sv
// Random-stimulus bench for dense_weight_fetcher against a queue-based reference.
// Define FETCH_CHECKSUM_EN to also cover the checksum output.
module tb_dense_weight_fetcher;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = AW + 1;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
`ifdef FETCH_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  dense_weight_fetcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dense_weight_fetcher #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
`ifdef FETCH_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  int ready_pct = 100;
  int n_checks  = 0;
  int n_errors  = 0;

  // Synchronous ROM: one-cycle latency, q forced to 0 when not enabled
  always @(posedge clk) bus.rom_q <= bus.rom_ena ? mem[bus.rom_addr] : '0;

  initial bus.m_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.m_ready = (int'($urandom_range(99)) < ready_pct);
  end

  int            neg_cnt = 0;
  int            busy_cnt, ena_cnt, valid_cnt, done_cnt, done_neg, first_valid_neg;
  int            stab_err, max_out;
  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] data_q [$];
  logic          last_q [$];
  int            beat_neg [$];
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    busy_cnt = 0; ena_cnt = 0; valid_cnt = 0; done_cnt = 0; done_neg = -1;
    first_valid_neg = -1; stab_err = 0; max_out = 0; hold_prev = 1'b0;
    addr_q.delete(); data_q.delete(); last_q.delete(); beat_neg.delete();
  endtask

  // Observe the DUT mid-cycle and record reads, beats and handshake behaviour
  always @(negedge clk) begin
    neg_cnt++;
    if (busy) busy_cnt++;
    if (bus.rom_ena) begin
      addr_q.push_back(bus.rom_addr);
      ena_cnt++;
    end
    if (bus.m_valid) begin
      valid_cnt++;
      if (first_valid_neg < 0) first_valid_neg = neg_cnt;
    end
    if (hold_prev && (!bus.m_valid || bus.m_data !== hold_data || bus.m_last !== hold_last))
      stab_err++;
    hold_prev = bus.m_valid && !bus.m_ready;
    hold_data = bus.m_data;
    hold_last = bus.m_last;
    if (bus.m_valid && bus.m_ready) begin
      data_q.push_back(bus.m_data);
      last_q.push_back(bus.m_last);
      beat_neg.push_back(neg_cnt);
    end
    if (done) begin
      done_cnt++;
      done_neg = neg_cnt;
    end
    if (ena_cnt - data_q.size() > max_out) max_out = ena_cnt - data_q.size();
  end

  task automatic run_cmd(input int b, input int n, input int pct, input int mid_len, input string tag);
    int start_neg;
    int sum;
    int idx;
    ready_pct = pct;
    @(posedge clk); #1;
    clear_mon();
    start = 1'b1; base_addr = AW'(b); len = LW'(n);
    start_neg = neg_cnt + 1;
    @(posedge clk); #1;
    start = 1'b0;
    if (mid_len > 0) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = ~base_addr; len = LW'(mid_len);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n * 20 + 100 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);

    check({tag, "_busy_end"}, 32'(busy), 32'(0));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
    check({tag, "_rom_ena_cnt"}, 32'(ena_cnt), 32'(n));
    check({tag, "_beat_cnt"}, 32'(data_q.size()), 32'(n));
    check({tag, "_stable"}, 32'(stab_err), 32'(0));
    check({tag, "_outstanding"}, 32'((max_out > 2) ? max_out : 2), 32'(2));
    sum = 0;
    for (int i = 0; i < n; i++) begin
      idx = (b + i) % DEPTH;
      sum = (sum + int'(mem[idx])) % 65536;
      if (i < addr_q.size()) check({tag, "_addr"}, 32'(addr_q[i]), 32'(idx));
      if (i < data_q.size()) begin
        check({tag, "_data"}, 32'(data_q[i]), 32'(mem[idx]));
        check({tag, "_last"}, 32'(last_q[i]), 32'(i == n - 1));
      end
    end
    if (n == 0) check({tag, "_no_valid"}, 32'(valid_cnt), 32'(0));
    if (pct == 100 && n > 0) begin
      check({tag, "_first_valid"}, 32'(first_valid_neg), 32'(start_neg + 3));
      check({tag, "_done_time"}, 32'(done_neg), 32'(start_neg + n + 3));
      check({tag, "_busy_len"}, 32'(busy_cnt), 32'(n + 3));
      if (beat_neg.size() == n)
        check({tag, "_no_bubbles"}, 32'(beat_neg[n-1] - beat_neg[0]), 32'(n - 1));
    end
`ifdef FETCH_CHECKSUM_EN
    check({tag, "_checksum"}, 32'(checksum), 32'(sum));
`endif
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    clear_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rom_ena", 32'(bus.rom_ena), 32'(0));
    check("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    check("rst_m_data", 32'(bus.m_data), 32'(0));
    check("rst_m_last", 32'(bus.m_last), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(32'h10, 4, 100, 0, "basic");
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    run_cmd(32'hFE, 4, 100, 0, "wrap");
    run_cmd(int'($urandom_range(255)), 8, 50, 0, "backpressure");
    for (int k = 0; k < 6; k++)
      run_cmd(int'($urandom_range(255)), int'($urandom_range(1, 40)),
              int'($urandom_range(20, 100)), 0, "random");
    run_cmd(32'h33, 0, 100, 0, "len0");
    run_cmd(0, 256, 100, 0, "len256");
    run_cmd(int'($urandom_range(255)), 5, 100, 2, "start_busy");

    // Reset in the middle of a command, with a word in flight and one buffered
    ready_pct = 100;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(8'h40); len = LW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_rom_ena", 32'(bus.rom_ena), 32'(0));
    check("midrst_rom_addr", 32'(bus.rom_addr), 32'(0));
    check("midrst_m_valid", 32'(bus.m_valid), 32'(0));
    check("midrst_m_data", 32'(bus.m_data), 32'(0));
    check("midrst_m_last", 32'(bus.m_last), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    repeat (6) @(negedge clk);
    check("postrst_no_valid", 32'(valid_cnt), 32'(0));
    check("postrst_no_read", 32'(ena_cnt), 32'(0));
    check("postrst_no_done", 32'(done_cnt), 32'(0));
    run_cmd(int'($urandom_range(255)), 6, 70, 0, "after_rst");

`ifdef FETCH_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
    run_cmd(0, 256, 100, 0, "cksum256");
    check("cksum_ff00", 32'(checksum), 32'h0000FF00);
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = LW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("cksum_clear", 32'(checksum), 32'(0));
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    repeat (2) @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
